// File: rtl/ultra_ram_burst_reader.sv
// Burst read sequencer for a 1-cycle-latency UltraRAM: issues contiguous reads
// from base_addr and streams the returned words through a 2-entry credit-controlled skid buffer.
module ultra_ram_burst_reader #(
   parameter int unsigned WIDTH      = 72,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned DEPTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DEPTH_BITS-1:0] base_addr,
   input  logic [DEPTH_BITS:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_read_en,
   output logic [DEPTH_BITS-1:0] ram_read_address,
   input  logic [WIDTH-1:0]      ram_read_data,
   output logic                  m_valid,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_last,
   input  logic                  m_ready
);

   localparam int unsigned CW = DEPTH_BITS + 1;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                state_q, state_d;
   logic [DEPTH_BITS-1:0] addr_q;
   logic [CW-1:0]         len_q;
   logic [CW-1:0]         issue_cnt_q;
   logic [CW-1:0]         pop_cnt_q;
   logic                  inflight_q;
   logic [WIDTH-1:0]      mem_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            buf_count_q;

   logic valid_c, pop_c, push_c, last_c, credit_c;

   assign valid_c  = (buf_count_q != 2'd0);
   assign pop_c    = valid_c & m_ready;
   assign push_c   = inflight_q;
   assign last_c   = (pop_cnt_q == len_q - CW'(1));
   // Reserve a buffer slot for every read in flight; a same-cycle pop frees one.
   assign credit_c = (3'({1'b0, buf_count_q}) + 3'(inflight_q)) < (3'd2 + 3'(pop_c));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (length == CW'(0)) ? FINISH : RUN;
         RUN:     if (pop_c && last_c) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy             = (state_q != IDLE);
      done             = (state_q == FINISH);
      ram_read_en      = (state_q == RUN) && (issue_cnt_q < len_q) && credit_c;
      ram_read_address = addr_q;
      m_valid          = valid_c;
      m_data           = mem_q[rd_ptr_q];
      m_last           = valid_c & last_c;
   end

   // Address/count registers and skid buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         pop_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         buf_count_q <= 2'd0;
      end else begin
         inflight_q <= ram_read_en;
         if (state_q == IDLE && start) begin
            addr_q      <= base_addr;
            len_q       <= length;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
         end
         if (ram_read_en) begin
            addr_q      <= (addr_q == DEPTH_BITS'(DEPTH - 1)) ? '0 : addr_q + DEPTH_BITS'(1);
            issue_cnt_q <= issue_cnt_q + CW'(1);
         end
         if (push_c) begin
            mem_q[wr_ptr_q] <= ram_read_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_c) begin
            rd_ptr_q  <= ~rd_ptr_q;
            pop_cnt_q <= pop_cnt_q + CW'(1);
         end
         case ({push_c, pop_c})
            2'b10:   buf_count_q <= buf_count_q + 2'd1;
            2'b01:   buf_count_q <= buf_count_q - 2'd1;
            default: buf_count_q <= buf_count_q;
         endcase
      end
   end

   // The credit rule must make a push into a full buffer impossible
   assert property (@(posedge clk) disable iff (rst)
      !(push_c && !pop_c && buf_count_q == 2'd2));

endmodule

// File: tb/tb_ultra_ram_burst_reader.sv
// Directed bench for ultra_ram_burst_reader with a RAM model and a scoreboard
// of expected read addresses and stream words.
module tb_ultra_ram_burst_reader;

   localparam int unsigned WIDTH = 72;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned DB    = 10;
   localparam int unsigned CW    = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [DB-1:0]    base_addr;
   logic [DB:0]      length;
   logic             busy, done, ram_read_en;
   logic [DB-1:0]    ram_read_address;
   logic [WIDTH-1:0] ram_read_data;
   logic             m_valid, m_last, m_ready;
   logic [WIDTH-1:0] m_data;

   always #5 clk = ~clk;

   ultra_ram_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_BITS(DB)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .ram_read_en(ram_read_en),
      .ram_read_address(ram_read_address), .ram_read_data(ram_read_data),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
   );

   // RAM model with one-cycle registered read
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) if (ram_read_en) ram_read_data <= mem[ram_read_address];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int issued = 0;
   int popped = 0;
   logic             hold_pend = 1'b0;
   logic [WIDTH-1:0] hold_data;
   logic [DB-1:0]    addr_q [$];
   logic [WIDTH:0]   word_q [$];

   task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle checks, sampled at the falling edge
   task automatic monitor();
      if (hold_pend) begin
         chk("stable_valid", CW'(m_valid), CW'(1));
         chk("stable_data", CW'(m_data), CW'(hold_data));
      end
      chk("outstanding_le2", CW'((issued - popped) <= 2), CW'(1));
      if (ram_read_en) begin
         if (addr_q.size() == 0) chk("spurious_read", CW'(ram_read_en), CW'(0));
         else chk("read_addr", CW'(ram_read_address), CW'(addr_q.pop_front()));
         issued++;
      end
      if (m_valid && m_ready) begin
         if (word_q.size() == 0) chk("spurious_word", CW'(m_valid), CW'(0));
         else chk("word_last_data", {m_last, m_data}, word_q.pop_front());
         popped++;
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Run one burst; exp_done is the cycle offset of done from the start cycle (-1: don't check)
   task automatic run_burst(input int base, input int len, input logic [15:0] pat,
                            input int plen, input int exp_done, input int restart_at);
      int d0, k;
      for (int i = 0; i < len; i++) begin
         addr_q.push_back(DB'((base + i) % DEPTH));
         word_q.push_back({i == len - 1, mem[(base + i) % DEPTH]});
      end
      d0        = done_cnt;
      k         = cyc;
      start     = 1'b1;
      base_addr = DB'(base);
      length    = (DB + 1)'(len);
      m_ready   = pat[0];
      tick();
      start = 1'b0;
      chk("busy_after_start", CW'(busy), CW'(1));
      for (int t = 1; t < 300 && done_cnt == d0; t++) begin
         m_ready = pat[t % plen];
         if (t == restart_at) begin
            start     = 1'b1;
            base_addr = DB'(100);
            length    = (DB + 1)'(3);
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      chk("done_once", CW'(done_cnt - d0), CW'(1));
      if (exp_done >= 0) chk("done_cycle", CW'(done_cyc), CW'(k + exp_done));
      chk("busy_after_done", CW'(busy), CW'(0));
      chk("done_pulse_width", CW'(done), CW'(0));
      chk("words_left", CW'(word_q.size()), CW'(0));
      chk("reads_left", CW'(addr_q.size()), CW'(0));
   endtask

   initial begin
      int d_before;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      m_ready   = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++)
         mem[i] = {8'(i * 13), 32'($urandom), 32'(i)};
      #1;
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_done", CW'(done), CW'(0));
      chk("rst_valid", CW'(m_valid), CW'(0));
      chk("rst_last", CW'(m_last), CW'(0));
      chk("rst_rd_en", CW'(ram_read_en), CW'(0));
      chk("rst_addr", CW'(ram_read_address), CW'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Basic burst, full throughput: done N+3 cycles after the start cycle
      run_burst(5, 4, 16'h0001, 1, 7, -1);
      tick();
      // Backpressure with ready pattern 1,0,0,1,0,1,1
      run_burst(5, 4, 16'b1101001, 7, -1, -1);
      tick();
      // Zero length: done in the cycle right after acceptance, no reads or words
      run_burst(7, 0, 16'h0001, 1, 1, -1);
      tick();
      // Address wrap at DEPTH
      run_burst(1022, 4, 16'h0001, 1, 7, -1);
      tick();
      // Start while busy must be ignored
      run_burst(20, 5, 16'h0001, 1, 8, 2);
      tick();
      // Long burst with light backpressure
      run_burst(300, 12, 16'b1011, 4, -1, -1);
      tick();

      // Reset in the middle of a 6-word burst after 2 pops
      for (int i = 0; i < 6; i++) begin
         addr_q.push_back(DB'(10 + i));
         word_q.push_back({i == 5, mem[10 + i]});
      end
      popped    = 0;
      issued    = 0;
      start     = 1'b1;
      base_addr = DB'(10);
      length    = (DB + 1)'(6);
      m_ready   = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 20 && popped < 2; t++) tick();
      chk("popped_before_rst", CW'(popped), CW'(2));
      d_before = done_cnt;
      rst = 1'b1;
      #1;
      chk("midrst_valid", CW'(m_valid), CW'(0));
      chk("midrst_busy", CW'(busy), CW'(0));
      chk("midrst_rd_en", CW'(ram_read_en), CW'(0));
      addr_q.delete();
      word_q.delete();
      issued    = 0;
      popped    = 0;
      hold_pend = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("midrst_no_done", CW'(done_cnt - d_before), CW'(0));
      run_burst(0, 2, 16'h0001, 1, 5, -1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ultra_ram_burst_reader.md
Name: ultra_ram_burst_reader

Overview:
- Read-side sequencer for a single-port-read UltraRAM buffer such as weight or activation storage.
- On a start command it issues a contiguous burst of RAM reads beginning at a base address.
- The RAM has 1-cycle registered read latency. Returned words are presented on a valid/ready stream to the downstream MAC/layer engine.
- A 2-entry credit-controlled skid buffer gives full throughput and lossless backpressure.

Parameters:
- WIDTH, 72, data word width; must match the RAM word width.
- DEPTH, 1024, number of RAM addresses; addresses wrap at DEPTH-1 -> 0.
- DEPTH_BITS, 10, RAM address width; ceil(log2(DEPTH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  DEPTH_BITS  first address of burst; sampled with start.
- length  input  DEPTH_BITS+1  words in burst, 0..DEPTH; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle completion pulse.
- ram_read_en  output  1  to RAM read_en.
- ram_read_address  output  DEPTH_BITS  to RAM read_address.
- ram_read_data  input  WIDTH  from RAM read_data_out; valid 1 cycle after ram_read_en.
- m_valid  output  1  stream valid.
- m_data  output  WIDTH  stream data (buffer head).
- m_last  output  1  high with the final word of the burst.
- m_ready  input  1  stream ready from consumer.

Behaviour:
- Reset (async, immediate):
  - State=IDLE; busy, done, m_valid, m_last and ram_read_en are all 0.
  - ram_read_address=0.
  - Buffer emptied, in-flight flag cleared, counters zeroed.
  - Any RAM data returning after reset deassertion is discarded.
- State machine: IDLE, RUN, FINISH.
  - IDLE: if start=1 at an edge, latch base_addr and length, set issue_cnt=0 and pop_cnt=0.
    - length>0 -> RUN.
    - length=0 -> FINISH; no RAM reads issued.
  - RUN: issue reads and pop words. -> FINISH at the edge where the pop with pop_cnt=length-1 occurs.
  - FINISH: done=1 for exactly this one cycle. -> IDLE.
- busy=1 in RUN and FINISH. start is ignored in RUN and FINISH; no queueing.
- Issue rule, combinational and evaluated in RUN:
  - pop = m_valid & m_ready.
  - ram_read_en = (issue_cnt < length) & (buf_count + inflight - pop < 2).
- Address:
  - ram_read_address = current address register, initialised to base_addr.
  - On each issue it increments; DEPTH-1 wraps to 0, i.e. a modular wrap at DEPTH, not 2^DEPTH_BITS.
- Return path:
  - inflight <= ram_read_en each edge.
  - When inflight=1, ram_read_data is pushed into the buffer at the next edge.
  - Push and pop in the same cycle are legal and leave buf_count unchanged.
  - The buffer never overflows, guaranteed by the credit rule; an overflow is an assertion failure.
- Stream:
  - m_valid = buf_count>0; m_data = head entry.
  - m_last = m_valid & (pop_cnt == length-1).
  - Once m_valid=1, m_data holds stable until popped (AXI-style).
- Latency: start accepted at edge E0 -> ram_read_en=1 in cycle after E0 -> first m_valid=1 after E2.
- Throughput: with m_ready held high, one word per cycle after the first. A burst of N words completes with done in cycle E(N+2).
- Mid-burst reset: aborts immediately. No done pulse. Next start behaves as from power-up.
- Widths: issue_cnt and pop_cnt are DEPTH_BITS+1 bits, so length=DEPTH is representable.

Test Plan:
- Basic burst: base=5, length=4, RAM[5..8]=A,B,C,D, m_ready=1. Expect:
  - ram_read_en 1 for 4 consecutive cycles with addresses 5,6,7,8.
  - m_data A,B,C,D on consecutive cycles; m_last only with D.
  - done pulse one cycle after the D handshake; busy low afterwards.
- Backpressure: same burst with m_ready toggled 1,0,0,1,0,1,1. Expect:
  - Every word delivered exactly once, in order, with m_data stable while m_valid & !m_ready.
  - Never more than 2 reads outstanding (buf_count+inflight<=2).
- Zero length: start with length=0. Expect ram_read_en never asserted, m_valid never asserted, busy=1 and done=1 in the single cycle after acceptance.
- Wrap: DEPTH=1024, base=1022, length=4. Expect ram_read_address 1022,1023,0,1 and correct data order.
- Start while busy: second start mid-burst with base=100. Expect it ignored; addresses continue from the original burst; exactly one done pulse.
- Reset mid-burst: assert rst after 2 of 6 words popped. Expect:
  - m_valid, busy and ram_read_en go 0 immediately; no done pulse.
  - A new burst base=0, length=2 then returns RAM[0], RAM[1] with no stale words.
